// File: rtl/easyaxi_rd_slv_if.sv
// AR/R channel bundle between an EasyAXI read master and the read responder.
interface easyaxi_rd_slv_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_LEN_WIDTH  = 8
);
    logic                      arvalid;
    logic                      arready;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [AXI_ID_WIDTH-1:0]   arid;
    logic [AXI_LEN_WIDTH-1:0]  arlen;
    logic                      rvalid;
    logic                      rready;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [AXI_ID_WIDTH-1:0]   rid;
    logic [1:0]                rresp;
    logic                      rlast;

    modport master (
        output arvalid, araddr, arid, arlen, rready,
        input  arready, rvalid, rdata, rid, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, rready,
        output arready, rvalid, rdata, rid, rresp, rlast
    );
endinterface

// File: rtl/easyaxi_rd_slv.sv
// Single-outstanding AXI read responder; first beat RD_LAT+1 cycles after AR, then one beat per cycle.
// R payload holds under rready backpressure; arready only in IDLE with enable set.
module easyaxi_rd_slv #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int RD_LAT         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    easyaxi_rd_slv_if.slave  axi_slv
);
    localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(BEAT_BYTES);
    localparam logic [3:0] LAT_LAST = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [3:0]                lat_q;
    logic [AXI_LEN_WIDTH-1:0]  beat_q;
    logic [AXI_LEN_WIDTH-1:0]  len_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic                      err_q;
    logic                      ar_unaligned;
    logic                      ar_hs;
    logic                      r_hs;
    logic                      last_beat;
    logic                      arready_w;
    logic                      rvalid_w;

    generate
        if (ADDR_LSB == 0) begin : g_byte_bus
            assign ar_unaligned = 1'b0;
        end else begin : g_word_bus
            assign ar_unaligned = |axi_slv.araddr[ADDR_LSB-1:0];
        end
    endgenerate

    assign last_beat = (beat_q == len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        arready_w = 1'b0;
        rvalid_w  = 1'b0;
        ar_hs     = 1'b0;
        r_hs      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // rst term keeps arready at its reset value while reset is held
                arready_w = enable & ~rst;
                if (axi_slv.arvalid & arready_w) begin
                    ar_hs   = 1'b1;
                    state_d = (RD_LAT == 0) ? ST_DATA : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                rvalid_w = 1'b1;
                if (axi_slv.rready) begin
                    r_hs = 1'b1;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_q  <= '0;
            beat_q <= '0;
            len_q  <= '0;
            addr_q <= '0;
            id_q   <= '0;
            err_q  <= 1'b0;
        end else if (ar_hs) begin
            lat_q  <= '0;
            beat_q <= '0;
            len_q  <= axi_slv.arlen;
            addr_q <= axi_slv.araddr;
            id_q   <= axi_slv.arid;
            err_q  <= ar_unaligned;
        end else if (state_q == ST_WAIT) begin
            lat_q <= lat_q + 4'd1;
        end else if (r_hs && !last_beat) begin
            // address is never realigned, so an unaligned start stays unaligned
            beat_q <= beat_q + 1'b1;
            addr_q <= addr_q + AXI_ADDR_WIDTH'(BEAT_BYTES);
        end
    end

    assign axi_slv.arready = arready_w;
    assign axi_slv.rvalid  = rvalid_w;
    assign axi_slv.rdata   = AXI_DATA_WIDTH'(addr_q);
    assign axi_slv.rid     = id_q;
    assign axi_slv.rresp   = err_q ? 2'b10 : 2'b00;
    assign axi_slv.rlast   = rvalid_w & last_beat;
endmodule
